lcd_text_driver: RTL

//  Downstream display stage for the top-level design. Owns a 32-character text buffer (2 rows x 16 chars).

---
 rtl/lcd_pkg.sv | 43 ++++
 rtl/lcd_nibble_tx.sv | 106 ++++++++++
 rtl/lcd_text_driver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the character-LCD driver.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h28;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ROW0     = 8'h80;
  localparam logic [7:0] ROW1     = 8'hC0;

  typedef enum logic [1:0] {
    POR_WAIT,
    INIT_NIB,
    INIT_BYTE,
    REFRESH
  } drv_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP_HI,
    TX_PULSE_HI,
    TX_GAP,
    TX_SETUP_LO,
    TX_PULSE_LO,
    TX_CMD
  } tx_state_e;

  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = FUNC_SET;
      2'd1:    b = ENTRY;
      2'd2:    b = DISP_ON;
      default: b = CLEAR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Serialises one byte (or a lone init nibble) onto the 4-bit LCD bus with
// setup, enable pulse, inter-nibble gap and post-byte command delay.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EPULSE  = 12,
  parameter int unsigned T_NIB_GAP = 50,
  parameter int unsigned T_CMD     = 2000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       nibble_mode_i,
  input  logic       rs_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       lcde_o,
  output logic       lcdrs_o,
  output logic [3:0] lcddat_o
);

  localparam int unsigned TM_A = (T_SETUP > T_EPULSE) ? T_SETUP : T_EPULSE;
  localparam int unsigned TM_B = (T_NIB_GAP > T_CMD) ? T_NIB_GAP : T_CMD;
  localparam int unsigned TMAX = (TM_A > TM_B) ? TM_A : TM_B;
  localparam int unsigned CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(T_EPULSE - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(T_NIB_GAP - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(T_CMD - 1);

  tx_state_e     st_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic [3:0]    lo_q;
  logic          lcde_q;
  logic          rs_q;
  logic [3:0]    dat_q;

  assign busy_o   = (st_q != TX_IDLE);
  // done marks the last cycle of a transfer so the next one can start back-to-back
  assign done_o   = (cnt_q == '0) && ((st_q == TX_PULSE_HI && mode_q) || st_q == TX_CMD);
  assign lcde_o   = lcde_q;
  assign lcdrs_o  = rs_q;
  assign lcddat_o = dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q   <= TX_IDLE;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      lo_q   <= '0;
      lcde_q <= 1'b0;
      rs_q   <= 1'b0;
      dat_q  <= '0;
    end else if (start_i && (!busy_o || done_o)) begin
      st_q   <= TX_SETUP_HI;
      cnt_q  <= SETUP_LD;
      mode_q <= nibble_mode_i;
      lo_q   <= byte_i[3:0];
      lcde_q <= 1'b0;
      rs_q   <= rs_i;
      dat_q  <= byte_i[7:4];
    end else if (st_q != TX_IDLE) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        case (st_q)
          TX_SETUP_HI: begin
            st_q   <= TX_PULSE_HI;
            lcde_q <= 1'b1;
            cnt_q  <= PULSE_LD;
          end
          TX_PULSE_HI: begin
            lcde_q <= 1'b0;
            if (mode_q) begin
              st_q <= TX_IDLE;
            end else begin
              st_q  <= TX_GAP;
              cnt_q <= GAP_LD;
            end
          end
          TX_GAP: begin
            st_q  <= TX_SETUP_LO;
            dat_q <= lo_q;
            cnt_q <= SETUP_LD;
          end
          TX_SETUP_LO: begin
            st_q   <= TX_PULSE_LO;
            lcde_q <= 1'b1;
            cnt_q  <= PULSE_LD;
          end
          TX_PULSE_LO: begin
            st_q   <= TX_CMD;
            lcde_q <= 1'b0;
            cnt_q  <= CMD_LD;
          end
          default: st_q <= TX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// 2x16 text buffer with HD44780 4-bit init sequence and continuous refresh.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_POR     = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EPULSE  = 12,
  parameter int unsigned T_NIB_GAP = 50,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLR     = 82000
) (
  input  logic       CCLK,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       LCDE,
  output logic       LCDRS,
  output logic       LCDRW,
  output logic [3:0] LCDDAT
);

  localparam int unsigned TM_A = (T_POR > T_INIT1) ? T_POR : T_INIT1;
  localparam int unsigned TMAX = (TM_A > T_CLR) ? TM_A : T_CLR;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] POR_LAST = TW'(T_POR - 1);
  localparam logic [TW-1:0] INIT1_LD = TW'(T_INIT1 - 1);
  localparam logic [TW-1:0] INIT2_LD = TW'(T_INIT2 - 1);
  localparam logic [TW-1:0] CMD_LD   = TW'(T_CMD - 1);
  // The transmitter already idles T_CMD after the Clear byte; only the remainder is waited here.
  localparam logic [TW-1:0] CLR_LD   = TW'((T_CLR > T_CMD) ? (T_CLR - T_CMD - 1) : 0);

  drv_state_e    state_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    step_q;
  logic          hold_q;
  logic          ready_q;
  logic [4:0]    addr_q;
  logic          row_cmd_q;
  logic [7:0]    text_q [32];

  logic          tx_start, tx_mode, tx_rs, tx_busy, tx_done, tx_free;
  logic [7:0]    tx_byte;
  logic [TW-1:0] nib_wait;

  assign tx_free = !tx_busy || tx_done;
  assign ready   = ready_q;
  assign LCDRW   = 1'b0;

  always_comb begin
    case (step_q)
      2'd0:    nib_wait = INIT1_LD;
      2'd1:    nib_wait = INIT2_LD;
      default: nib_wait = CMD_LD;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    tx_mode  = 1'b0;
    tx_rs    = 1'b0;
    tx_byte  = '0;
    case (state_q)
      POR_WAIT: if (timer_q == POR_LAST) begin
        tx_start = 1'b1;
        tx_mode  = 1'b1;
        tx_byte  = {init_nibble(2'd0), 4'h0};
      end
      INIT_NIB: if (hold_q && timer_q == '0) begin
        tx_start = 1'b1;
        if (step_q == 2'd3) begin
          tx_byte = init_byte(2'd0);
        end else begin
          tx_mode = 1'b1;
          tx_byte = {init_nibble(step_q + 2'd1), 4'h0};
        end
      end
      INIT_BYTE: if (tx_done && step_q != 2'd3) begin
        tx_start = 1'b1;
        tx_byte  = init_byte(step_q + 2'd1);
      end
      REFRESH: if (tx_free) begin
        tx_start = 1'b1;
        if (row_cmd_q) begin
          tx_byte = addr_q[4] ? ROW1 : ROW0;
        end else begin
          tx_rs   = 1'b1;
          tx_byte = text_q[addr_q];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      state_q   <= POR_WAIT;
      timer_q   <= '0;
      step_q    <= '0;
      hold_q    <= 1'b0;
      ready_q   <= 1'b0;
      addr_q    <= '0;
      row_cmd_q <= 1'b1;
    end else begin
      case (state_q)
        // POR counts up from the reset value; every later wait loads and counts down.
        POR_WAIT: begin
          if (timer_q == POR_LAST) begin
            state_q <= INIT_NIB;
            step_q  <= '0;
            hold_q  <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        INIT_NIB: begin
          if (!hold_q) begin
            if (tx_done) begin
              hold_q  <= 1'b1;
              timer_q <= nib_wait;
            end
          end else if (timer_q == '0) begin
            hold_q <= 1'b0;
            if (step_q == 2'd3) begin
              state_q <= INIT_BYTE;
              step_q  <= '0;
            end else begin
              step_q <= step_q + 2'd1;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        INIT_BYTE: begin
          if (!hold_q) begin
            if (tx_done) begin
              if (step_q == 2'd3) begin
                hold_q  <= 1'b1;
                timer_q <= CLR_LD;
              end else begin
                step_q <= step_q + 2'd1;
              end
            end
          end else if (timer_q == '0) begin
            hold_q    <= 1'b0;
            state_q   <= REFRESH;
            ready_q   <= 1'b1;
            addr_q    <= '0;
            row_cmd_q <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        REFRESH: begin
          if (tx_start) begin
            if (row_cmd_q) begin
              row_cmd_q <= 1'b0;
            end else begin
              addr_q    <= addr_q + 5'd1;
              row_cmd_q <= (addr_q[3:0] == 4'hF);
            end
          end
        end
        default: state_q <= POR_WAIT;
      endcase
    end
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) text_q[i] <= 8'h20;
    end else if (wr_en) begin
      text_q[wr_addr] <= wr_data;
    end
  end

  lcd_nibble_tx #(
    .T_SETUP  (T_SETUP),
    .T_EPULSE (T_EPULSE),
    .T_NIB_GAP(T_NIB_GAP),
    .T_CMD    (T_CMD)
  ) u_tx (
    .clk_i        (CCLK),
    .rst_i        (rst),
    .start_i      (tx_start),
    .nibble_mode_i(tx_mode),
    .rs_i         (tx_rs),
    .byte_i       (tx_byte),
    .busy_o       (tx_busy),
    .done_o       (tx_done),
    .lcde_o       (LCDE),
    .lcdrs_o      (LCDRS),
    .lcddat_o     (LCDDAT)
  );

endmodule
